// File: rtl/register_window_controller_pkg.sv
// Shared definitions for the register-window controller: window geometry,
// clear-sweep length, controller state and register_file rw encodings.
package register_window_controller_pkg;

    localparam int NWINDOWS_DEFAULT = 4;
    localparam int CWP_W_DEFAULT    = 2;
    localparam int DATA_W_DEFAULT   = 32;
    localparam int REGS_PER_WINDOW  = 32;
    localparam int RNUM_W           = 5;

    function automatic int sweep_len(input int nwindows);
        return nwindows * REGS_PER_WINDOW;
    endfunction

    localparam int SWEEP_LEN = sweep_len(NWINDOWS_DEFAULT);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/register_window_controller_window_clear_sequencer.sv
// Post-reset sweep counter: walks every (window, r_num) location once and
// flags the final location so the controller can leave the clear phase.
module window_clear_sequencer
    import register_window_controller_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEFAULT,
    parameter int CWP_W    = CWP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              active,
    output logic [CWP_W-1:0]  window,
    output logic [RNUM_W-1:0] r_num,
    output logic              done
);

    localparam int CNT_W = CWP_W + RNUM_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(sweep_len(NWINDOWS) - 1);

    logic [CNT_W-1:0] cnt;

    // The count wraps to zero on the last location and then holds while idle.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign window = cnt[CNT_W-1 -: CWP_W];
    assign r_num  = cnt[RNUM_W-1:0];
    assign done   = active && (cnt == LAST);

endmodule

// File: rtl/register_window_controller.sv
// Current window pointer / window invalid mask owner for the windowed
// register_file; resolves window moves and raises overflow/underflow traps.
module register_window_controller
    import register_window_controller_pkg::*;
#(
    parameter int NWINDOWS = NWINDOWS_DEFAULT,
    parameter int CWP_W    = CWP_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                save,
    input  logic                restore,
    input  logic                trap_entry,
    input  logic                rett,
    input  logic                wr_cwp,
    input  logic [CWP_W-1:0]    cwp_in,
    input  logic                wr_wim,
    input  logic [NWINDOWS-1:0] wim_in,
    output logic                ready,
    output logic [CWP_W-1:0]    current_window,
    output logic [NWINDOWS-1:0] wim,
    output logic                overflow_trap,
    output logic                underflow_trap,
    output logic                rf_enable,
    output logic                rf_rw,
    output logic [CWP_W-1:0]    rf_window,
    output logic [RNUM_W-1:0]   rf_r_num,
    output logic [DATA_W-1:0]   rf_in
);

    state_t state, state_nxt;

    logic [CWP_W-1:0]    cwp_q, cwp_nxt, cwp_minus, cwp_plus;
    logic [NWINDOWS-1:0] wim_q, wim_nxt;
    logic                ovf_q, ovf_nxt, unf_q, unf_nxt;

    logic [CWP_W-1:0]  sweep_window;
    logic [RNUM_W-1:0] sweep_r_num;
    logic              sweep_done;

    window_clear_sequencer #(
        .NWINDOWS (NWINDOWS),
        .CWP_W    (CWP_W)
    ) u_clear_seq (
        .clk    (Clk),
        .clr_n  (Clr),
        .active (state == CLEAR),
        .window (sweep_window),
        .r_num  (sweep_r_num),
        .done   (sweep_done)
    );

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_done) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        rf_enable = 1'b1;
        rf_rw     = RW_WRITE;
        rf_window = sweep_window;
        rf_r_num  = sweep_r_num;
        if (state == RUN) begin
            ready     = 1'b1;
            rf_enable = 1'b0;
            rf_rw     = RW_READ;
            rf_window = cwp_q;
            rf_r_num  = '0;
        end
    end

    // Window moves wrap naturally because NWINDOWS == 2**CWP_W.
    assign cwp_minus = cwp_q - CWP_W'(1);
    assign cwp_plus  = cwp_q + CWP_W'(1);

    always_comb begin
        cwp_nxt = cwp_q;
        wim_nxt = wim_q;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (state == RUN) begin
            if (trap_entry) begin
                cwp_nxt = cwp_minus;
            end else if (wr_cwp) begin
                cwp_nxt = cwp_in;
            end else if (save) begin
                if (wim_q[cwp_minus]) ovf_nxt = 1'b1;
                else                  cwp_nxt = cwp_minus;
            end else if (restore || rett) begin
                if (wim_q[cwp_plus]) unf_nxt = 1'b1;
                else                 cwp_nxt = cwp_plus;
            end
            // The trap checks above deliberately see the pre-write mask.
            if (wr_wim) wim_nxt = wim_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            cwp_q <= '0;
            wim_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_nxt;
            wim_q <= wim_nxt;
            ovf_q <= ovf_nxt;
            unf_q <= unf_nxt;
        end
    end

    assign current_window = cwp_q;
    assign wim            = wim_q;
    assign overflow_trap  = ovf_q;
    assign underflow_trap = unf_q;
    assign rf_in          = '0;

endmodule

// File: tb/tb_register_window_controller.sv
// Scoreboard bench for register_window_controller: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_register_window_controller;

    logic       Clk = 1'b0;
    logic       Clr;
    logic       save, restore, trap_entry, rett, wr_cwp, wr_wim;
    logic [1:0] cwp_in;
    logic [3:0] wim_in;
    logic       ready, overflow_trap, underflow_trap, rf_enable, rf_rw;
    logic [1:0] current_window, rf_window;
    logic [3:0] wim;
    logic [4:0] rf_r_num;
    logic [31:0] rf_in;

    register_window_controller #(
        .NWINDOWS (4),
        .CWP_W    (2),
        .DATA_W   (32)
    ) dut (
        .Clk            (Clk),
        .Clr            (Clr),
        .save           (save),
        .restore        (restore),
        .trap_entry     (trap_entry),
        .rett           (rett),
        .wr_cwp         (wr_cwp),
        .cwp_in         (cwp_in),
        .wr_wim         (wr_wim),
        .wim_in         (wim_in),
        .ready          (ready),
        .current_window (current_window),
        .wim            (wim),
        .overflow_trap  (overflow_trap),
        .underflow_trap (underflow_trap),
        .rf_enable      (rf_enable),
        .rf_rw          (rf_rw),
        .rf_window      (rf_window),
        .rf_r_num       (rf_r_num),
        .rf_in          (rf_in)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [17:0] vec;
    } exp_t;

    exp_t expq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Packed as {ready, cwp, wim, ovf, unf, rf_enable, rf_rw, rf_window, rf_r_num}
    function automatic logic [17:0] run_vec(input logic [1:0] c, input logic [3:0] w,
                                            input logic ovf, input logic unf);
        return {1'b1, c, w, ovf, unf, 1'b0, 1'b1, c, 5'd0};
    endfunction

    function automatic logic [17:0] clr_vec(input logic [1:0] win, input logic [4:0] rn);
        return {1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, win, rn};
    endfunction

    task automatic push(input int at, input string nm, input logic [17:0] v);
        exp_t e;
        e.cyc = at; e.name = nm; e.vec = v;
        expq.push_back(e);
    endtask

    always @(negedge Clk) begin
        logic [17:0] act;
        exp_t e;
        act = {ready, current_window, wim, overflow_trap, underflow_trap,
               rf_enable, rf_rw, rf_window, rf_r_num};
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         e.name, e.cyc, cyc);
            end else if (act !== e.vec || rf_in !== 32'd0) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got rdy/cwp/wim/ovf/unf/en/rw/win/rn=%b_%b_%b_%b_%b_%b_%b_%b_%b rf_in=%h, expected %b_%b_%b_%b_%b_%b_%b_%b_%b rf_in=0",
                         e.name, cyc, act[17], act[16:15], act[14:11], act[10], act[9],
                         act[8], act[7], act[6:5], act[4:0], rf_in,
                         e.vec[17], e.vec[16:15], e.vec[14:11], e.vec[10], e.vec[9],
                         e.vec[8], e.vec[7], e.vec[6:5], e.vec[4:0]);
            end
        end
    end

    task automatic idle_inputs();
        save = 0; restore = 0; trap_entry = 0; rett = 0;
        wr_cwp = 0; wr_wim = 0; cwp_in = 2'd0; wim_in = 4'd0;
    endtask

    // Inputs set by the caller take effect at the next edge; result checked after it.
    task automatic run_cycle(input string nm, input logic [1:0] c, input logic [3:0] w,
                             input logic ovf, input logic unf);
        push(cyc + 1, nm, run_vec(c, w, ovf, unf));
        @(posedge Clk); #1;
        idle_inputs();
    endtask

    task automatic sweep_cycle(input string nm, input int k);
        push(cyc + 1, nm, clr_vec(2'(k >> 5), 5'(k & 31)));
        @(posedge Clk); #1;
    endtask

    initial begin
        idle_inputs();
        Clr = 1'b0;
        @(posedge Clk); #1;
        sweep_cycle("reset", 0);
        Clr = 1'b1;

        // Full sweep; requests thrown at the controller mid-sweep must be ignored.
        for (int k = 1; k < 128; k++) begin
            if (k == 50) begin
                save = 1; wr_wim = 1; wim_in = 4'hF; wr_cwp = 1; cwp_in = 2'd2;
            end else begin
                idle_inputs();
            end
            sweep_cycle("sweep", k);
        end
        idle_inputs();
        push(cyc + 1, "ready_rise", run_vec(2'd0, 4'd0, 0, 0));
        @(posedge Clk); #1;

        save = 1;                   run_cycle("save_wrap",      2'd3, 4'b0000, 0, 0);
        restore = 1;                run_cycle("restore_wrap",   2'd0, 4'b0000, 0, 0);
        save = 1;                   run_cycle("save_to_3",      2'd3, 4'b0000, 0, 0);
        wr_wim = 1; wim_in = 4'b0100; run_cycle("wr_wim_0100",  2'd3, 4'b0100, 0, 0);
        save = 1;                   run_cycle("save_overflow",  2'd3, 4'b0100, 1, 0);
        run_cycle("ovf_clears",                                  2'd3, 4'b0100, 0, 0);
        restore = 1;                run_cycle("restore_to_0",   2'd0, 4'b0100, 0, 0);
        wr_wim = 1; wim_in = 4'b0010; run_cycle("wr_wim_0010",  2'd0, 4'b0010, 0, 0);
        rett = 1;                   run_cycle("rett_underflow", 2'd0, 4'b0010, 0, 1);
        trap_entry = 1;             run_cycle("trap_entry",     2'd3, 4'b0010, 0, 0);
        trap_entry = 1; wr_wim = 1; wim_in = 4'b0100;
                                    run_cycle("trap_no_check",  2'd2, 4'b0100, 0, 0);
        wr_cwp = 1; cwp_in = 2'd0; wr_wim = 1; wim_in = 4'b0000;
                                    run_cycle("wr_cwp_wim_0",   2'd0, 4'b0000, 0, 0);
        save = 1; restore = 1; wr_cwp = 1; cwp_in = 2'd2;
                                    run_cycle("wr_cwp_priority", 2'd2, 4'b0000, 0, 0);
        wr_cwp = 1; cwp_in = 2'd0;  run_cycle("wr_cwp_0",       2'd0, 4'b0000, 0, 0);
        save = 1; wr_wim = 1; wim_in = 4'b1000;
                                    run_cycle("save_old_wim",   2'd3, 4'b1000, 0, 0);
        save = 1;                   run_cycle("save_b2b",       2'd2, 4'b1000, 0, 0);
        restore = 1;                run_cycle("restore_uflow",  2'd2, 4'b1000, 0, 1);
        trap_entry = 1; save = 1;   run_cycle("trap_over_save", 2'd1, 4'b1000, 0, 0);
        restore = 1; rett = 1;      run_cycle("restore_rett",   2'd2, 4'b1000, 0, 0);

        // Reset from RUN, then again at sweep count 60 while save is held.
        Clr = 1'b0;
        sweep_cycle("reset_in_run", 0);
        Clr = 1'b1;
        save = 1;
        for (int k = 1; k <= 60; k++) sweep_cycle("sweep2", k);
        Clr = 1'b0;
        sweep_cycle("reset_mid_sweep", 0);
        Clr = 1'b1;
        for (int k = 1; k < 128; k++) sweep_cycle("sweep3", k);
        idle_inputs();
        push(cyc + 1, "ready_after_restart", run_vec(2'd0, 4'd0, 0, 0));
        @(posedge Clk); #1;
        save = 1;                   run_cycle("save_after_restart", 2'd3, 4'b0000, 0, 0);

        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge Clk);
        @(negedge Clk); #1;
        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                     e.name, e.cyc, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_window_controller.md
Name: register_window_controller

Overview:
Owns the current window pointer (CWP) and window invalid mask (WIM) for the windowed register_file. Executes SAVE/RESTORE/trap-entry/RETT window moves and flags window overflow/underflow traps. After reset it runs a clear sweep that writes zero to every (window, r_num) location of the register_file through its write port. Sits between the decode/trap logic and the register_file's current_window/r_num/rw/enable inputs.

Parameters:
NWINDOWS, 4, number of register windows; must be a power of 2, at least 2.
CWP_W, 2, width of the window pointer, equal to log2(NWINDOWS).
DATA_W, 32, register_file data width.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Clr  input  1  synchronous, active-low reset.
save  input  1  SAVE request, sampled each cycle.
restore  input  1  RESTORE request.
trap_entry  input  1  trap taken; CWP decrements with no WIM check.
rett  input  1  RETT request; checked like RESTORE.
wr_cwp  input  1  direct CWP write (WRPSR).
cwp_in  input  CWP_W  value for wr_cwp.
wr_wim  input  1  WIM write.
wim_in  input  NWINDOWS  value for wr_wim.
ready  output  1  high once the clear sweep is done; requests are honoured only when high.
current_window  output  CWP_W  CWP; drives register_file current_window outside the sweep.
wim  output  NWINDOWS  current WIM.
overflow_trap  output  1  one-cycle pulse: SAVE hit an invalid window.
underflow_trap  output  1  one-cycle pulse: RESTORE/RETT hit an invalid window.
rf_enable  output  1  register_file enable during the sweep.
rf_rw  output  1  register_file rw; 0 = write during the sweep, 1 otherwise.
rf_window  output  CWP_W  window index presented to register_file.
rf_r_num  output  5  register number presented to register_file during the sweep.
rf_in  output  DATA_W  write data; constant 0.

Behaviour:
- Reset (Clr=0 at an edge): CWP=0, WIM=0, state=CLEAR, sweep counter=0, ready=0, both trap outputs=0, rf_enable=1, rf_rw=0. Reset mid-sweep or in RUN restarts the sweep from 0.
- CLEAR state: the sweep counter spans CWP_W+5 bits. rf_window = counter[upper CWP_W bits] and rf_r_num = counter[4:0]. One write per cycle, so the sweep takes NWINDOWS*32 cycles (128 by default).
- Aliased out/in locations are written more than once; this is acceptable.
- When the counter reaches its terminal count, the next state is RUN. ready=1, rf_enable=0 and rf_rw=1 from the first RUN cycle.
- In CLEAR, all requests including wr_wim and wr_cwp are ignored; nothing is queued.
- RUN state: rf_window = CWP and rf_r_num = 0.
- Window arithmetic: minus = (CWP-1) mod NWINDOWS and plus = (CWP+1) mod NWINDOWS, both as natural CWP_W-bit wrap.
- Priority in one cycle: trap_entry > wr_cwp > save > restore > rett. Only the winner acts.
- trap_entry: CWP <= minus unconditionally, with no trap flag.
- wr_cwp: CWP <= cwp_in.
- save: if WIM[minus]=1, CWP is unchanged and overflow_trap=1 next cycle. Otherwise CWP <= minus.
- restore / rett: if WIM[plus]=1, CWP is unchanged and underflow_trap=1 next cycle. Otherwise CWP <= plus.
- wr_wim is independent of the priority chain. WIM <= wim_in at the same edge, and the trap check in that cycle uses the old WIM.
- Latency: the CWP/WIM update and the trap pulse are all visible one cycle after the request edge. Trap flags are registered, last one cycle, and clear automatically.
- Back-to-back requests on consecutive cycles are each evaluated against the updated CWP.

Decomposition:
- Shared package (register-window package):
  - NWINDOWS and CWP_W defaults.
  - Sweep length constant NWINDOWS*32.
  - State encoding CLEAR=1'b0, RUN=1'b1.
  - Rf_rw encodings RW_WRITE=0, RW_READ=1.
- One natural sub-module, window_clear_sequencer: the sweep counter plus rf_window/rf_r_num/done generation.
- The top level holds CWP/WIM, priority resolution and trap flags.

Test Plan:
- Clr=0 for 2 cycles, then 1 -> rf_rw=0 with rf_r_num 0..31 per window 0..3; ready rises exactly 128 cycles after reset release; CWP=0, WIM=0.
- Default WIM=0, then save from CWP=0 -> CWP=3 next cycle; restore -> CWP=0 (wrap both directions); no trap pulses.
- wr_wim with wim_in=4'b0100 at CWP=3, then save -> overflow_trap pulses 1 cycle and CWP stays 3; restore -> CWP=0.
- CWP=0, WIM=4'b0010, rett -> underflow_trap pulse and CWP stays 0; trap_entry -> CWP=3 with no trap.
- save+restore+wr_cwp(cwp_in=2) in the same cycle -> CWP=2, no trap. Separately, wr_wim=4'b1000 with save at CWP=0 -> save succeeds to 3 because the old WIM was checked, and WIM=1000 afterwards.
- Clr=0 at sweep cycle 60 -> ready stays 0 and the sweep restarts at window 0, r_num 0; save asserted during CLEAR is ignored.
